// File: rtl/mock_miso_gen.sv
// -----------------------------------------------------------------------------
// mock_miso_gen
//
// Two-channel mock SPI slave data source (SPI mode 0). Each channel waits for
// its slave select to fall and then shifts a fixed pattern out MSB-first, one
// bit per falling sck edge. Frames repeat back-to-back while the select stays
// low. A rising select aborts the frame.
//
// sck, ss1 and ss2 are asynchronous to clk. Each passes through a 2-flop
// synchronizer plus a third flop that is used only for edge detection.
//
// Parameters
//   DATA_W    bits per frame (2..32)
//   PATTERN1  channel-1 frame content
//   PATTERN2  channel-2 frame content
//
// Ports
//   clk         system clock, all state on its rising edge
//   rst         asynchronous active-high reset
//   sck         SPI serial clock from the master (asynchronous)
//   ss1, ss2    active-low slave selects (asynchronous)
//   mock_miso1  channel-1 serial data to the tristate stage
//   mock_miso2  channel-2 serial data to the tristate stage
//   busy1/2     channel is in SHIFT
//   done1/2     one-clk pulse when a channel completes a frame
//   collision   both synchronized selects are low
// -----------------------------------------------------------------------------
module mock_miso_gen #(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  PATTERN1 = DATA_W'(8'hA5),
  parameter logic [DATA_W-1:0]  PATTERN2 = DATA_W'(8'h3C)
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ss1,
  input  logic ss2,
  output logic mock_miso1,
  output logic mock_miso2,
  output logic busy1,
  output logic busy2,
  output logic done1,
  output logic done2,
  output logic collision
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  // Channel patterns packed so the generate loop can select by index.
  localparam logic [2*DATA_W-1:0] PATTERNS = {PATTERN2, PATTERN1};

  // Synchronizer chains: [0] first flop, [1] second (synchronized value),
  // [2] third (previous synchronized value, for edge detection).
  logic [2:0] sck_sync_reg;
  logic [2:0] ss1_sync_reg;
  logic [2:0] ss2_sync_reg;

  // Right after reset the chains hold forced 1s rather than real samples. An
  // edge seen against those forced values is not a genuine pin transition
  // (e.g. a select held low through reset), so edges are only honoured once
  // all three flops carry real samples.
  logic [2:0] settle_reg;
  logic       sync_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_reg <= 3'b111;
      ss1_sync_reg <= 3'b111;
      ss2_sync_reg <= 3'b111;
      settle_reg   <= 3'b000;
    end else begin
      sck_sync_reg <= {sck_sync_reg[1:0], sck};
      ss1_sync_reg <= {ss1_sync_reg[1:0], ss1};
      ss2_sync_reg <= {ss2_sync_reg[1:0], ss2};
      settle_reg   <= {settle_reg[1:0], 1'b1};
    end
  end

  assign sync_valid = settle_reg[2];

  logic       sck_fall;
  logic [1:0] ss_fall;
  logic [1:0] ss_rise;

  assign sck_fall   = sync_valid &  sck_sync_reg[2] & ~sck_sync_reg[1];
  assign ss_fall[0] = sync_valid &  ss1_sync_reg[2] & ~ss1_sync_reg[1];
  assign ss_fall[1] = sync_valid &  ss2_sync_reg[2] & ~ss2_sync_reg[1];
  assign ss_rise[0] = sync_valid & ~ss1_sync_reg[2] &  ss1_sync_reg[1];
  assign ss_rise[1] = sync_valid & ~ss2_sync_reg[2] &  ss2_sync_reg[1];

  assign collision = ~ss1_sync_reg[1] & ~ss2_sync_reg[1];

  logic [1:0] mock_vec;
  logic [1:0] busy_vec;
  logic [1:0] done_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic [DATA_W-1:0] PAT = PATTERNS[gi*DATA_W +: DATA_W];

      typedef enum logic {IDLE, SHIFT} state_t;

      state_t            state_reg;
      logic [DATA_W-1:0] shift_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic              mock_reg;
      logic              done_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= IDLE;
          shift_reg <= '0;
          cnt_reg   <= '0;
          mock_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end else begin
          done_reg <= 1'b0;
          case (state_reg)
            IDLE: begin
              mock_reg <= 1'b0;
              cnt_reg  <= '0;
              // A coincident sck fall is ignored here: the MSB must be held
              // for a full bit time before the master samples it.
              if (ss_fall[gi]) begin
                shift_reg <= PAT;
                mock_reg  <= PAT[DATA_W-1];
                state_reg <= SHIFT;
              end
            end
            SHIFT: begin
              // Deselect wins over a simultaneous sck fall.
              if (ss_rise[gi]) begin
                state_reg <= IDLE;
                mock_reg  <= 1'b0;
                cnt_reg   <= '0;
              end else if (sck_fall) begin
                if (cnt_reg == LAST_BIT) begin
                  // Reload immediately so the next frame follows with no gap.
                  shift_reg <= PAT;
                  mock_reg  <= PAT[DATA_W-1];
                  cnt_reg   <= '0;
                  done_reg  <= 1'b1;
                end else begin
                  shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                  mock_reg  <= shift_reg[DATA_W-2];
                  cnt_reg   <= cnt_reg + 1'b1;
                end
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign mock_vec[gi] = mock_reg;
      assign busy_vec[gi] = (state_reg == SHIFT);
      assign done_vec[gi] = done_reg;
    end
  endgenerate

  assign mock_miso1 = mock_vec[0];
  assign mock_miso2 = mock_vec[1];
  assign busy1      = busy_vec[0];
  assign busy2      = busy_vec[1];
  assign done1      = done_vec[0];
  assign done2      = done_vec[1];

endmodule
